// File: rtl/board_game_ctrl_if.sv
// Bundle of the controller's control inputs and board/score outputs.
// master = the side that drives clicks and commands (click decoder / bench),
// slave  = the game controller itself.
interface board_game_ctrl_if #(
    parameter int BOARD_N = 3,
    parameter int IDX_W   = 4,
    parameter int SCORE_W = 6
);
    localparam int CELLS = BOARD_N * BOARD_N;

    logic               start;
    logic               cell_valid;
    logic [IDX_W-1:0]   cell_idx;
    logic               restart;
    logic               reset_score;

    logic [CELLS-1:0]   x_matrix;
    logic [CELLS-1:0]   o_matrix;
    logic               turn_x;
    logic [2:0]         state;
    logic               display_start;
    logic               display_win_x;
    logic               display_win_o;
    logic               display_tie;
    logic               inc_x_score;
    logic               inc_o_score;
    logic [SCORE_W-1:0] score_x;
    logic [SCORE_W-1:0] score_o;
    logic [IDX_W:0]     move_count;

    modport master (
        output start, cell_valid, cell_idx, restart, reset_score,
        input  x_matrix, o_matrix, turn_x, state,
        input  display_start, display_win_x, display_win_o, display_tie,
        input  inc_x_score, inc_o_score, score_x, score_o, move_count
    );

    modport slave (
        input  start, cell_valid, cell_idx, restart, reset_score,
        output x_matrix, o_matrix, turn_x, state,
        output display_start, display_win_x, display_win_o, display_tie,
        output inc_x_score, inc_o_score, score_x, score_o, move_count
    );
endinterface

// File: rtl/board_game_ctrl.sv
// N x N tic-tac-toe game controller.
// Holds both occupancy matrices, turn, round state and saturating scores.
// Win detection walks one line per cycle (rows, columns, main diagonal,
// anti-diagonal) against the mover's matrix, so it scales with BOARD_N
// without a wide combinational compare tree.
// Optional feature macro: ALTERNATE_START_EN -- the first mover alternates
// between rounds (first_x flips each time a round is abandoned/finished).
module board_game_ctrl #(
    parameter int BOARD_N   = 3,
    parameter int IDX_W     = 4,
    parameter int SCORE_W   = 6,
    parameter int SCORE_MAX = 63
) (
    input logic              clk_100MHz,
    input logic              reset,
    board_game_ctrl_if.slave bus
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int LINES  = 2 * BOARD_N + 2;
    localparam int LINE_W = $clog2(LINES);
    localparam int MC_W   = IDX_W + 1;

    localparam logic [MC_W-1:0]    CELLS_V   = MC_W'(CELLS);
    localparam logic [LINE_W-1:0]  LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

    typedef enum logic [2:0] {
        START = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN_X = 3'd3,
        WIN_O = 3'd4,
        TIE   = 3'd5
    } state_t;

    // Cell mask of one winning line: rows first, then columns, then the
    // main diagonal and finally the anti-diagonal.
    function automatic logic [CELLS-1:0] line_mask_of(input int line);
        logic [CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                if ((line < BOARD_N && r == line) ||
                    (line >= BOARD_N && line < 2 * BOARD_N && c == line - BOARD_N) ||
                    (line == 2 * BOARD_N && r == c) ||
                    (line == 2 * BOARD_N + 1 && r + c == BOARD_N - 1))
                    m[r * BOARD_N + c] = 1'b1;
            end
        end
        return m;
    endfunction

    logic [CELLS-1:0] line_mask [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            assign line_mask[gi] = line_mask_of(gi);
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [CELLS-1:0]   x_reg, x_next;
    logic [CELLS-1:0]   o_reg, o_next;
    logic               turn_x_reg, turn_x_next;
    logic [MC_W-1:0]    move_count_reg, move_count_next;
    logic [LINE_W-1:0]  line_idx_reg, line_idx_next;
    logic               inc_x_reg, inc_x_next;
    logic               inc_o_reg, inc_o_next;
    logic [SCORE_W-1:0] score_x_reg, score_x_next;
    logic [SCORE_W-1:0] score_o_reg, score_o_next;
    logic               round_first;
`ifdef ALTERNATE_START_EN
    logic               first_x_reg, first_x_next;
    assign round_first = first_x_reg;
`else
    assign round_first = 1'b1;
`endif

    logic [CELLS-1:0] occ_shift;
    logic [CELLS-1:0] click_bit;
    logic [CELLS-1:0] cur_mask;
    logic [CELLS-1:0] mover;
    logic             click_ok;
    logic             line_hit;

    // A click is legal only on an in-range cell that neither player holds.
    assign occ_shift = (x_reg | o_reg) >> bus.cell_idx;
    assign click_bit = CELLS'(1) << bus.cell_idx;
    assign click_ok  = bus.cell_valid && ({1'b0, bus.cell_idx} < CELLS_V) && !occ_shift[0];

    // Only the player who just moved can have completed a line.
    assign cur_mask = line_mask[line_idx_reg];
    assign mover    = turn_x_reg ? x_reg : o_reg;
    assign line_hit = (mover & cur_mask) == cur_mask;

    // State register and all round/score state.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg      <= START;
            x_reg          <= '0;
            o_reg          <= '0;
            turn_x_reg     <= 1'b1;
            move_count_reg <= '0;
            line_idx_reg   <= '0;
            inc_x_reg      <= 1'b0;
            inc_o_reg      <= 1'b0;
            score_x_reg    <= '0;
            score_o_reg    <= '0;
`ifdef ALTERNATE_START_EN
            first_x_reg    <= 1'b1;
`endif
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            o_reg          <= o_next;
            turn_x_reg     <= turn_x_next;
            move_count_reg <= move_count_next;
            line_idx_reg   <= line_idx_next;
            inc_x_reg      <= inc_x_next;
            inc_o_reg      <= inc_o_next;
            score_x_reg    <= score_x_next;
            score_o_reg    <= score_o_next;
`ifdef ALTERNATE_START_EN
            first_x_reg    <= first_x_next;
`endif
        end
    end

    // Next-state logic: restart overrides everything, then per-state moves.
    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        o_next          = o_reg;
        turn_x_next     = turn_x_reg;
        move_count_next = move_count_reg;
        line_idx_next   = line_idx_reg;
        inc_x_next      = 1'b0;
        inc_o_next      = 1'b0;
`ifdef ALTERNATE_START_EN
        first_x_next    = first_x_reg;
`endif

        if (bus.restart && state_reg != START) begin
            // Any pending line scan is dropped, so no score pulse can follow.
            state_next      = START;
            x_next          = '0;
            o_next          = '0;
            move_count_next = '0;
            line_idx_next   = '0;
`ifdef ALTERNATE_START_EN
            first_x_next    = ~first_x_reg;
            turn_x_next     = ~first_x_reg;
`else
            turn_x_next     = 1'b1;
`endif
        end else begin
            case (state_reg)
                START: begin
                    if (bus.start) begin
                        state_next      = PLAY;
                        x_next          = '0;
                        o_next          = '0;
                        move_count_next = '0;
                        line_idx_next   = '0;
                        turn_x_next     = round_first;
                    end
                end
                PLAY: begin
                    if (click_ok) begin
                        if (turn_x_reg)
                            x_next = x_reg | click_bit;
                        else
                            o_next = o_reg | click_bit;
                        move_count_next = move_count_reg + MC_W'(1);
                        line_idx_next   = '0;
                        state_next      = CHECK;
                    end
                end
                CHECK: begin
                    if (line_hit) begin
                        state_next = turn_x_reg ? WIN_X : WIN_O;
                        inc_x_next = turn_x_reg;
                        inc_o_next = ~turn_x_reg;
                    end else if (line_idx_reg == LAST_LINE) begin
                        if (move_count_reg == CELLS_V) begin
                            state_next = TIE;
                        end else begin
                            turn_x_next = ~turn_x_reg;
                            state_next  = PLAY;
                        end
                    end else begin
                        line_idx_next = line_idx_reg + LINE_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Scores saturate; a coincident clear beats the increment.
        score_x_next = score_x_reg;
        score_o_next = score_o_reg;
        if (inc_x_next && score_x_reg < SCORE_CAP)
            score_x_next = score_x_reg + SCORE_W'(1);
        if (inc_o_next && score_o_reg < SCORE_CAP)
            score_o_next = score_o_reg + SCORE_W'(1);
        if (bus.reset_score) begin
            score_x_next = '0;
            score_o_next = '0;
        end
    end

    assign bus.x_matrix      = x_reg;
    assign bus.o_matrix      = o_reg;
    assign bus.turn_x        = turn_x_reg;
    assign bus.state         = state_reg;
    assign bus.move_count    = move_count_reg;
    assign bus.inc_x_score   = inc_x_reg;
    assign bus.inc_o_score   = inc_o_reg;
    assign bus.score_x       = score_x_reg;
    assign bus.score_o       = score_o_reg;
    assign bus.display_start = (state_reg == START);
    assign bus.display_win_x = (state_reg == WIN_X);
    assign bus.display_win_o = (state_reg == WIN_O);
    assign bus.display_tie   = (state_reg == TIE);
endmodule
